// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt entry and MRET return sequencing.
// Redirects the PC, flushes the front end and clears the controller's mretFlag.
module csr_trap_unit #(
   parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
   parameter int unsigned IRQ_SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_reg_rd,
   input  logic        csr_reg_wr,
   input  logic        mret_flag,
   input  logic [11:0] csr_addr,
   input  logic [2:0]  csr_funct3,
   input  logic [4:0]  csr_zimm,
   input  logic [31:0] csr_wdata,
   input  logic [31:0] pc_in,
   input  logic        timer_irq,
   input  logic        ext_irq,
   output logic [31:0] csr_rdata,
   output logic        intr_kill,
   output logic        epc_taken,
   output logic [31:0] epc_out,
   output logic        flush,
   output logic        low_mret
);

   localparam int unsigned XLEN       = 32;
   localparam int unsigned CODE_W     = 5;
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [CODE_W-1:0] CODE_MEI = CODE_W'(11);
   localparam logic [CODE_W-1:0] CODE_MTI = CODE_W'(7);

   typedef enum logic [1:0] {IDLE, REDIRECT, SETTLE} state_t;

   state_t state, state_nx;

   logic                       mstatus_mie, mstatus_mpie;
   logic                       mie_mtie, mie_meie;
   logic [XLEN-1:0]            mtvec_q, mepc_q, mcause_q, target_q;
   logic [IRQ_SYNC_STAGES-1:0] timer_sync, ext_sync;

   logic                       mtip, meip, pend, trap_ext, is_idle;
   logic                       take_mret, take_trap, do_write;
   logic [CODE_W-1:0]          trap_code;
   logic [XLEN-1:0]            trap_cause, trap_base, trap_target;
   logic [XLEN-1:0]            mstatus_val, mie_val, mip_val;
   logic [XLEN-1:0]            old_val, src_val, new_val;

   // Interrupt lines are asynchronous levels; resynchronise before use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_sync <= '0;
         ext_sync   <= '0;
      end else begin
         timer_sync[0] <= timer_irq;
         ext_sync[0]   <= ext_irq;
         for (int i = 1; i < int'(IRQ_SYNC_STAGES); i++) begin
            timer_sync[i] <= timer_sync[i-1];
            ext_sync[i]   <= ext_sync[i-1];
         end
      end
   end

   assign mtip        = timer_sync[IRQ_SYNC_STAGES-1];
   assign meip        = ext_sync[IRQ_SYNC_STAGES-1];
   assign mstatus_val = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
   assign mie_val     = {20'h0, mie_meie, 3'b000, mie_mtie, 7'h00};
   assign mip_val     = {20'h0, meip, 3'b000, mtip, 7'h00};

   always_comb begin
      old_val = '0;
      case (csr_addr)
         A_MSTATUS: old_val = mstatus_val;
         A_MIE:     old_val = mie_val;
         A_MTVEC:   old_val = mtvec_q;
         A_MEPC:    old_val = mepc_q;
         A_MCAUSE:  old_val = mcause_q;
         A_MIP:     old_val = mip_val;
         default:   old_val = '0;
      endcase
   end

   assign csr_rdata = csr_reg_rd ? old_val : '0;
   assign src_val   = csr_funct3[2] ? XLEN'(csr_zimm) : csr_wdata;

   always_comb begin
      new_val = old_val;
      case (csr_funct3[1:0])
         2'b01:   new_val = src_val;
         2'b10:   new_val = old_val | src_val;
         2'b11:   new_val = old_val & ~src_val;
         default: new_val = old_val;
      endcase
   end

   assign is_idle   = (state == IDLE);
   assign do_write  = is_idle && csr_reg_wr && (csr_funct3[1:0] != 2'b00);
   assign pend      = mstatus_mie && ((mie_meie && meip) || (mie_mtie && mtip));
   assign take_mret = is_idle && mret_flag;
   assign take_trap = is_idle && !mret_flag && pend && !csr_reg_wr;

   // External interrupt outranks the timer when both are enabled and pending.
   assign trap_ext    = mie_meie && meip;
   assign trap_code   = trap_ext ? CODE_MEI : CODE_MTI;
   assign trap_cause  = {1'b1, 26'h0, trap_code};
   assign trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_target = (mtvec_q[1:0] == 2'b01) ? trap_base + (XLEN'(trap_code) << 2)
                                                : trap_base;

   // CSR writes first; MRET/trap updates below take precedence on shared bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_mtie     <= 1'b0;
         mie_meie     <= 1'b0;
         mtvec_q      <= MTVEC_RESET;
         mepc_q       <= '0;
         mcause_q     <= '0;
         target_q     <= '0;
      end else begin
         if (do_write) begin
            case (csr_addr)
               A_MSTATUS: begin
                  mstatus_mie  <= new_val[3];
                  mstatus_mpie <= new_val[7];
               end
               A_MIE: begin
                  mie_mtie <= new_val[7];
                  mie_meie <= new_val[11];
               end
               A_MTVEC:  mtvec_q  <= {new_val[XLEN-1:2], (new_val[1:0] == 2'b01) ? 2'b01 : 2'b00};
               A_MEPC:   mepc_q   <= new_val & ~XLEN'(3);
               A_MCAUSE: mcause_q <= new_val;
               default:  ;
            endcase
         end
         if (take_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            target_q     <= mepc_q;
         end else if (take_trap) begin
            mepc_q       <= pc_in & ~XLEN'(3);
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            mcause_q     <= trap_cause;
            target_q     <= trap_target;
         end
      end
   end

   assign epc_out = target_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      intr_kill = 1'b0;
      epc_taken = 1'b0;
      flush     = 1'b0;
      low_mret  = 1'b0;
      case (state)
         IDLE: begin
            intr_kill = take_trap;
            if (take_mret || take_trap) state_nx = REDIRECT;
         end
         REDIRECT: begin
            epc_taken = 1'b1;
            flush     = 1'b1;
            low_mret  = 1'b1;
            state_nx  = SETTLE;
         end
         SETTLE: begin
            flush    = 1'b1;
            low_mret = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: CSR access, trap entry, MRET, deferral, reset.
module tb_csr_trap_unit;

   localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;
   localparam logic [2:0]  F_RW      = 3'b001;
   localparam logic [2:0]  F_RS      = 3'b010;
   localparam logic [2:0]  F_RC      = 3'b011;
   localparam logic [2:0]  F_RSI     = 3'b110;

   logic        clk, rst_n;
   logic        csr_reg_rd, csr_reg_wr, mret_flag;
   logic [11:0] csr_addr;
   logic [2:0]  csr_funct3;
   logic [4:0]  csr_zimm;
   logic [31:0] csr_wdata, pc_in;
   logic        timer_irq, ext_irq;
   logic [31:0] csr_rdata, epc_out;
   logic        intr_kill, epc_taken, flush, low_mret;

   int checks = 0;
   int errors = 0;
   logic [31:0] redir_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] redir_exp;

   csr_trap_unit #(.MTVEC_RESET(MTVEC_RST), .IRQ_SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .csr_reg_rd(csr_reg_rd), .csr_reg_wr(csr_reg_wr), .mret_flag(mret_flag),
      .csr_addr(csr_addr), .csr_funct3(csr_funct3), .csr_zimm(csr_zimm),
      .csr_wdata(csr_wdata), .pc_in(pc_in),
      .timer_irq(timer_irq), .ext_irq(ext_irq),
      .csr_rdata(csr_rdata), .intr_kill(intr_kill), .epc_taken(epc_taken),
      .epc_out(epc_out), .flush(flush), .low_mret(low_mret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Every redirect the DUT issues must match the next expected target.
   always @(negedge clk) begin
      if (rst_n && epc_taken) begin
         if (redir_q.size() == 0) begin
            check("redir_unexpected", 32'(epc_taken), 32'h0);
         end else begin
            redir_exp = redir_q.pop_front();
            check("redir_target", epc_out, redir_exp);
         end
      end
   end

   task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      csr_reg_wr = 1'b1;
      csr_funct3 = f3;
      csr_addr   = a;
      csr_zimm   = d[4:0];
      csr_wdata  = f3[2] ? 32'hFFFF_FFFF : d;
      @(negedge clk);
      csr_reg_wr = 1'b0;
   endtask

   task automatic csr_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
      @(negedge clk);
      csr_reg_rd = 1'b1;
      csr_addr   = a;
      rd_q.push_back(exp);
      #1;
      check(tag, csr_rdata, rd_q.pop_front());
      csr_reg_rd = 1'b0;
   endtask

   task automatic wait_kill(input string tag, input int exp_cyc);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (intr_kill) begin
            seen = 1'b1;
            n = i;
         end
      end
      check(tag, 32'(n), 32'(exp_cyc));
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
         #1;
         if (!flush && !epc_taken) done = 1'b1;
      end
      check(tag, 32'(flush), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; csr_reg_rd = 1'b0; csr_reg_wr = 1'b0; mret_flag = 1'b0;
      csr_addr = '0; csr_funct3 = '0; csr_zimm = '0; csr_wdata = '0; pc_in = '0;
      timer_irq = 1'b0; ext_irq = 1'b0;

      // Reset state
      @(negedge clk); #1;
      check("rst_epc_taken", 32'(epc_taken), 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_low_mret", 32'(low_mret), 32'h0);
      check("rst_epc_out", epc_out, 32'h0);
      check("rst_rdata_idle", csr_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      csr_read("rst_mtvec", A_MTVEC, MTVEC_RST);
      csr_read("rst_mstatus", A_MSTATUS, 32'h0);

      // CSR access, legalisation and masking
      csr_op(F_RW, A_MTVEC, 32'h0000_0103);
      csr_read("mtvec_mode3", A_MTVEC, 32'h0000_0100);
      csr_op(F_RW, A_MTVEC, 32'h0000_0101);
      csr_read("mtvec_vec", A_MTVEC, 32'h0000_0101);
      csr_op(F_RW, 12'h340, 32'h0000_DEAD);
      csr_read("unmapped", 12'h340, 32'h0);
      csr_op(F_RW, A_MSTATUS, 32'hFFFF_FF77);
      csr_read("mstatus_mask", A_MSTATUS, 32'h0);
      csr_op(F_RW, A_MIE, 32'h0000_0880);
      csr_read("mie", A_MIE, 32'h0000_0880);
      csr_op(F_RSI, A_MSTATUS, 32'h0000_0008);
      csr_read("mstatus_rsi", A_MSTATUS, 32'h0000_0008);

      // Timer interrupt, vectored entry
      @(negedge clk);
      pc_in = 32'h40;
      timer_irq = 1'b1;
      redir_q.push_back(32'h0000_011C);
      wait_kill("timer_latency", 2);
      @(negedge clk); #1;
      check("redir_epc_taken", 32'(epc_taken), 32'h1);
      check("redir_flush", 32'(flush), 32'h1);
      check("redir_low_mret", 32'(low_mret), 32'h1);
      @(negedge clk); #1;
      check("settle_epc_taken", 32'(epc_taken), 32'h0);
      check("settle_flush", 32'(flush), 32'h1);
      wait_idle("timer_idle");
      csr_read("mip_timer", A_MIP, 32'h0000_0080);
      csr_op(F_RW, A_MIP, 32'h0);
      csr_read("mip_ro", A_MIP, 32'h0000_0080);
      csr_read("timer_mepc", A_MEPC, 32'h0000_0040);
      csr_read("timer_mcause", A_MCAUSE, 32'h8000_0007);
      csr_read("timer_mstatus", A_MSTATUS, 32'h0000_0080);
      timer_irq = 1'b0;

      // Both interrupts together: external wins
      csr_op(F_RS, A_MSTATUS, 32'h0000_0008);
      @(negedge clk);
      pc_in = 32'h80;
      timer_irq = 1'b1;
      ext_irq = 1'b1;
      redir_q.push_back(32'h0000_012C);
      wait_kill("both_latency", 2);
      wait_idle("both_idle");
      csr_read("both_mcause", A_MCAUSE, 32'h8000_000B);
      csr_read("both_mepc", A_MEPC, 32'h0000_0080);
      csr_read("both_mstatus", A_MSTATUS, 32'h0000_0080);
      timer_irq = 1'b0;
      ext_irq = 1'b0;
      repeat (3) @(negedge clk);

      // MRET, mret_flag held through the redirect window
      csr_op(F_RW, A_MEPC, 32'h0000_0043);
      csr_read("mepc_align", A_MEPC, 32'h0000_0040);
      @(negedge clk);
      mret_flag = 1'b1;
      redir_q.push_back(32'h0000_0040);
      @(negedge clk); #1;
      check("mret_redir_low", 32'(low_mret), 32'h1);
      check("mret_redir_flush", 32'(flush), 32'h1);
      @(negedge clk); #1;
      check("mret_settle_low", 32'(low_mret), 32'h1);
      check("mret_settle_flush", 32'(flush), 32'h1);
      check("mret_settle_epc", epc_out, 32'h0000_0040);
      @(negedge clk);
      mret_flag = 1'b0;
      #1;
      check("mret_done_low", 32'(low_mret), 32'h0);
      check("mret_done_flush", 32'(flush), 32'h0);
      csr_read("mret_mstatus", A_MSTATUS, 32'h0000_0088);

      // Interrupt arriving with a CSRRC is deferred one cycle
      @(negedge clk);
      ext_irq = 1'b1;
      pc_in = 32'h90;
      @(negedge clk);
      @(negedge clk);
      csr_reg_wr = 1'b1; csr_funct3 = F_RC; csr_addr = A_MIE; csr_wdata = 32'h80;
      #1;
      check("defer_kill", 32'(intr_kill), 32'h0);
      @(negedge clk);
      csr_reg_wr = 1'b0;
      redir_q.push_back(32'h0000_012C);
      #1;
      check("deferred_kill", 32'(intr_kill), 32'h1);
      wait_idle("defer_idle");
      csr_read("defer_mie", A_MIE, 32'h0000_0800);
      csr_read("defer_mepc", A_MEPC, 32'h0000_0090);
      csr_read("defer_mcause", A_MCAUSE, 32'h8000_000B);

      // MRET and a pending interrupt in the same cycle: MRET first
      @(negedge clk);
      csr_reg_wr = 1'b1; csr_funct3 = F_RS; csr_addr = A_MSTATUS; csr_wdata = 32'h8;
      @(negedge clk);
      csr_reg_wr = 1'b0;
      mret_flag = 1'b1;
      pc_in = 32'h94;
      redir_q.push_back(32'h0000_0090);
      #1;
      check("mret_wins_kill", 32'(intr_kill), 32'h0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mret_flag = 1'b0;
      redir_q.push_back(32'h0000_012C);
      #1;
      check("irq_after_mret", 32'(intr_kill), 32'h1);
      wait_idle("after_mret_idle");
      ext_irq = 1'b0;
      csr_read("after_mret_mepc", A_MEPC, 32'h0000_0094);
      repeat (3) @(negedge clk);

      // Reset during REDIRECT
      @(negedge clk);
      mret_flag = 1'b1;
      redir_q.push_back(32'h0000_0094);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      mret_flag = 1'b0;
      #1;
      check("rstmid_epc_taken", 32'(epc_taken), 32'h0);
      check("rstmid_flush", 32'(flush), 32'h0);
      check("rstmid_low_mret", 32'(low_mret), 32'h0);
      csr_reg_rd = 1'b1;
      csr_addr = A_MTVEC;
      #1;
      check("rstmid_mtvec", csr_rdata, MTVEC_RST);
      csr_addr = A_MSTATUS;
      #1;
      check("rstmid_mstatus", csr_rdata, 32'h0);
      csr_reg_rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("post_rst_flush", 32'(flush), 32'h0);
      check("sb_empty", 32'(redir_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and interrupt/return sequencer for the 3-stage RISC-V core.
- Sits in the execute stage, directly downstream of the instruction controller.
- Consumes the controller's csr_reg_rd, csr_reg_wr and mretFlag strobes plus instruction fields.
- Produces CSR read data for write-back (dm_mux_sel=3), PC redirects for interrupts and MRET, pipeline flush, and the low_mret feedback that clears the controller's mretFlag.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (base and mode).
- IRQ_SYNC_STAGES, 2, flip-flop synchroniser depth on timer_irq/ext_irq; legal values 1..3.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_reg_rd  in  1  CSR read strobe from controller
- csr_reg_wr  in  1  CSR write strobe from controller
- mret_flag  in  1  MRET decoded in EX
- csr_addr  in  12  instruction[31:20]
- csr_funct3  in  3  instruction[14:12]
- csr_zimm  in  5  instruction[19:15]
- csr_wdata  in  32  rs1 value
- pc_in  in  32  PC of instruction in EX
- timer_irq  in  1  asynchronous level timer interrupt
- ext_irq  in  1  asynchronous level external interrupt
- csr_rdata  out  32  addressed CSR old value
- intr_kill  out  1  suppress write-back/store of the EX instruction
- epc_taken  out  1  PC redirect valid
- epc_out  out  32  redirect target
- flush  out  1  squash fetch/decode
- low_mret  out  1  forces controller mretFlag low

Behaviour:
- CSR map:
  - mstatus 0x300: MIE bit3, MPIE bit7; other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11.
  - mtvec 0x305: [31:2] base, [1:0] mode; 0=direct, 1=vectored, 2/3 written as 0.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: MTIP bit7, MEIP bit11 from synchroniser outputs; read-only, writes ignored.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: all CSRs 0 except mtvec=MTVEC_RESET. Synchronisers 0, state IDLE. All outputs 0.
- Read path: csr_rdata is combinational, equal to the addressed CSR pre-write value when csr_reg_rd=1, else 0.
- Write path, on posedge when csr_reg_wr=1 and state=IDLE:
  - src = funct3[2] ? zero-extended csr_zimm : csr_wdata.
  - funct3[1:0]: 01 RW new=src; 10 RS new=old|src; 11 RC new=old&~src; 00 no write.
- Interrupt pending: pend = mstatus.MIE & ((MEIE&MEIP) | (MTIE&MTIP)).
- FSM states IDLE, REDIRECT, SETTLE.
- IDLE:
  - mret_flag=1: MRET accepted. Next state REDIRECT with target=mepc. At the edge MIE<=MPIE, MPIE<=1.
  - Else pend=1 and csr_reg_wr=0: trap accepted.
    - intr_kill=1 combinationally this cycle.
    - At the edge: mepc<=pc_in; MPIE<=MIE; MIE<=0; mcause<=32'h8000000B if MEIP enabled, else 32'h80000007 (external has priority).
    - Target = direct ? {base,00} : {base,00}+4*cause_code.
    - Next state REDIRECT.
  - pend with csr_reg_wr=1: trap deferred one cycle.
  - MRET and pend in the same cycle: MRET wins; the interrupt is reconsidered after return.
- REDIRECT, one cycle: epc_taken=1, epc_out=target register, flush=1, low_mret=1. Next state SETTLE.
- SETTLE, one cycle: flush=1, low_mret=1. Next state IDLE.
- Outside IDLE: mret_flag, pend and csr_reg_wr are ignored (flushed instructions must not commit).
- Reset asserted mid-REDIRECT/SETTLE: immediate return to IDLE, all outputs 0, CSRs restored to reset values.

Test Plan:
- CSRRW x0,mtvec,rs1=0x0000_0101, then CSRRS rd,mtvec,x0 -> csr_rdata=0x0000_0101; vectored mode set.
- mie=0x880, mstatus=0x8, timer_irq high with pc_in=0x40:
  - After sync latency: intr_kill pulse; next cycle epc_taken=1, epc_out=0x100+28=0x11C.
  - mepc=0x40, mcause=0x80000007, mstatus=0x80.
- timer_irq and ext_irq asserted together -> mcause=0x8000000B, epc_out=0x12C.
- MRET with mepc=0x40, mstatus=0x80:
  - epc_out=0x40 and low_mret=1 for 2 cycles; flush 2 cycles.
  - mstatus=0x88 after the return.
- ext_irq pending in the same cycle as a CSRRC and as an MRET -> trap deferred; CSR write lands; MRET redirect wins.
- rst_n low during REDIRECT -> epc_taken/flush drop immediately; mtvec=MTVEC_RESET, mstatus=0.
